// File: rtl/sccb_slave.sv
// SCCB/I2C target emulating the OV7670 register interface: oversampled and
// glitch-filtered bus inputs, 256x8 register file, ID registers at 0x0A/0x0B.
module sccb_slave #(
    parameter logic [6:0] DEVICE_ADDR   = 7'h21,
    parameter int         FILTER_CYCLES = 3,
    parameter logic [7:0] PID_VALUE     = 8'h76,
    parameter logic [7:0] VER_VALUE     = 8'h73
) (
    input  logic       iClock,
    input  logic       iReset,
    input  logic       iSCL,
    input  logic       iSDA,
    output logic       oSDA_OE,
    output logic       oRegWrite,
    output logic [7:0] oRegAddr,
    output logic [7:0] oRegData,
    output logic       oBusy,
    output logic [7:0] oLED
);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_ADDR      = 4'd1,
        S_ADDR_ACK  = 4'd2,
        S_SUB       = 4'd3,
        S_SUB_ACK   = 4'd4,
        S_WDATA     = 4'd5,
        S_WDATA_ACK = 4'd6,
        S_RDATA     = 4'd7,
        S_RDATA_ACK = 4'd8,
        S_IGNORE    = 4'd9
    } state_t;

    logic [1:0]               scl_sync_r, sda_sync_r;
    logic [FILTER_CYCLES-1:0] scl_hist_r, sda_hist_r;
    logic                     scl_filt_r, sda_filt_r, scl_prev_r, sda_prev_r;
    logic                     scl_rise_s, scl_fall_s, start_s, stop_s;

    state_t      state_r, state_nxt;
    logic [2:0]  cnt_r, cnt_nxt;
    logic [7:0]  shift_r, shift_nxt, tx_r, tx_nxt, ptr_r, ptr_nxt;
    logic        phase_r, phase_nxt, oe_r, oe_nxt, busy_r, busy_nxt;
    logic        wr_r, wr_nxt, match_r, match_nxt, ack_rx_r, ack_rx_nxt;
    logic        rw_r, rw_nxt, overrun_r, overrun_nxt;
    logic [7:0]  waddr_r, waddr_nxt, wdata_r, wdata_nxt;
    logic [7:0]  rx_byte_s, rd_data_s;
    logic        mem_we_s;
    logic [7:0]  regs_r [256];

    // Synchronize bus lines and accept a level only after FILTER_CYCLES equal samples.
    always_ff @(posedge iClock or negedge iReset) begin
        if (!iReset) begin
            scl_sync_r <= 2'b11;
            sda_sync_r <= 2'b11;
            scl_hist_r <= '1;
            sda_hist_r <= '1;
            scl_filt_r <= 1'b1;
            sda_filt_r <= 1'b1;
            scl_prev_r <= 1'b1;
            sda_prev_r <= 1'b1;
        end else begin
            scl_sync_r <= {scl_sync_r[0], iSCL};
            sda_sync_r <= {sda_sync_r[0], iSDA};
            scl_hist_r <= {scl_hist_r[FILTER_CYCLES-2:0], scl_sync_r[1]};
            sda_hist_r <= {sda_hist_r[FILTER_CYCLES-2:0], sda_sync_r[1]};
            if (&scl_hist_r)       scl_filt_r <= 1'b1;
            else if (~|scl_hist_r) scl_filt_r <= 1'b0;
            else                   scl_filt_r <= scl_filt_r;
            if (&sda_hist_r)       sda_filt_r <= 1'b1;
            else if (~|sda_hist_r) sda_filt_r <= 1'b0;
            else                   sda_filt_r <= sda_filt_r;
            scl_prev_r <= scl_filt_r;
            sda_prev_r <= sda_filt_r;
        end
    end

    assign scl_rise_s = scl_filt_r & ~scl_prev_r;
    assign scl_fall_s = ~scl_filt_r & scl_prev_r;
    assign start_s    = scl_filt_r & scl_prev_r & sda_prev_r & ~sda_filt_r;
    assign stop_s     = scl_filt_r & scl_prev_r & ~sda_prev_r & sda_filt_r;
    assign rx_byte_s  = {shift_r[6:0], sda_filt_r};

    // Register-file read port with the read-only ID registers overlaid.
    always_comb begin
        if (ptr_r == 8'h0A)      rd_data_s = PID_VALUE;
        else if (ptr_r == 8'h0B) rd_data_s = VER_VALUE;
        else                     rd_data_s = regs_r[ptr_r];
    end

    // Protocol FSM: STOP beats START, START beats any bit sample.
    always_comb begin
        state_nxt   = state_r;
        cnt_nxt     = cnt_r;
        shift_nxt   = shift_r;
        tx_nxt      = tx_r;
        ptr_nxt     = ptr_r;
        phase_nxt   = phase_r;
        oe_nxt      = oe_r;
        busy_nxt    = busy_r;
        wr_nxt      = 1'b0;
        waddr_nxt   = waddr_r;
        wdata_nxt   = wdata_r;
        match_nxt   = match_r;
        ack_rx_nxt  = ack_rx_r;
        rw_nxt      = rw_r;
        overrun_nxt = overrun_r;
        mem_we_s    = 1'b0;
        if (stop_s) begin
            state_nxt = S_IDLE;
            oe_nxt    = 1'b0;
            busy_nxt  = 1'b0;
            phase_nxt = 1'b0;
        end else if (start_s) begin
            state_nxt = S_ADDR;
            cnt_nxt   = 3'd0;
            oe_nxt    = 1'b0;
            phase_nxt = 1'b0;
            match_nxt = 1'b0;
        end else begin
            case (state_r)
                S_ADDR, S_SUB, S_WDATA: begin
                    if (scl_rise_s) begin
                        shift_nxt = rx_byte_s;
                        cnt_nxt   = cnt_r + 3'd1;
                        if (cnt_r != 3'd7) begin
                            state_nxt = state_r;
                        end else if (state_r == S_SUB) begin
                            ptr_nxt   = rx_byte_s;
                            state_nxt = S_SUB_ACK;
                        end else if (state_r == S_WDATA) begin
                            wr_nxt    = 1'b1;
                            waddr_nxt = ptr_r;
                            wdata_nxt = rx_byte_s;
                            mem_we_s  = (ptr_r != 8'h0A) && (ptr_r != 8'h0B);
                            ptr_nxt   = ptr_r + 8'd1;
                            overrun_nxt = overrun_r | (ptr_r == 8'hFF);
                            state_nxt = S_WDATA_ACK;
                        end else if (rx_byte_s[7:1] == DEVICE_ADDR) begin
                            match_nxt = 1'b1;
                            rw_nxt    = rx_byte_s[0];
                            state_nxt = S_ADDR_ACK;
                        end else begin
                            busy_nxt  = 1'b0;
                            state_nxt = S_IGNORE;
                        end
                    end else begin
                        shift_nxt = shift_r;
                    end
                end
                S_ADDR_ACK, S_SUB_ACK, S_WDATA_ACK: begin
                    // First falling edge drives the ACK, the second ends the 9th clock.
                    if (!scl_fall_s) begin
                        phase_nxt = phase_r;
                    end else if (!phase_r) begin
                        oe_nxt    = 1'b1;
                        phase_nxt = 1'b1;
                        busy_nxt  = 1'b1;
                    end else begin
                        phase_nxt = 1'b0;
                        cnt_nxt   = 3'd0;
                        oe_nxt    = 1'b0;
                        if (state_r != S_ADDR_ACK) begin
                            state_nxt = S_WDATA;
                        end else if (rw_r) begin
                            tx_nxt    = {rd_data_s[6:0], 1'b0};
                            oe_nxt    = ~rd_data_s[7];
                            ptr_nxt   = ptr_r + 8'd1;
                            state_nxt = S_RDATA;
                        end else begin
                            state_nxt = S_SUB;
                        end
                    end
                end
                S_RDATA: begin
                    if (!scl_fall_s) begin
                        tx_nxt = tx_r;
                    end else if (cnt_r == 3'd7) begin
                        oe_nxt    = 1'b0;
                        phase_nxt = 1'b0;
                        state_nxt = S_RDATA_ACK;
                    end else begin
                        oe_nxt  = ~tx_r[7];
                        tx_nxt  = {tx_r[6:0], 1'b0};
                        cnt_nxt = cnt_r + 3'd1;
                    end
                end
                S_RDATA_ACK: begin
                    if (scl_rise_s) begin
                        ack_rx_nxt = ~sda_filt_r;
                        if (sda_filt_r) begin
                            busy_nxt  = 1'b0;
                            oe_nxt    = 1'b0;
                            state_nxt = S_IGNORE;
                        end else begin
                            phase_nxt = 1'b1;
                        end
                    end else if (scl_fall_s && phase_r) begin
                        tx_nxt    = {rd_data_s[6:0], 1'b0};
                        oe_nxt    = ~rd_data_s[7];
                        ptr_nxt   = ptr_r + 8'd1;
                        cnt_nxt   = 3'd0;
                        phase_nxt = 1'b0;
                        state_nxt = S_RDATA;
                    end else begin
                        phase_nxt = phase_r;
                    end
                end
                S_IDLE, S_IGNORE: begin
                    state_nxt = state_r;
                end
                default: begin
                    oe_nxt    = 1'b0;
                    busy_nxt  = 1'b0;
                    state_nxt = S_IDLE;
                end
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge iClock or negedge iReset) begin
        if (!iReset) begin
            state_r   <= S_IDLE;
            cnt_r     <= 3'd0;
            shift_r   <= 8'h00;
            tx_r      <= 8'h00;
            ptr_r     <= 8'h00;
            phase_r   <= 1'b0;
            oe_r      <= 1'b0;
            busy_r    <= 1'b0;
            wr_r      <= 1'b0;
            waddr_r   <= 8'h00;
            wdata_r   <= 8'h00;
            match_r   <= 1'b0;
            ack_rx_r  <= 1'b0;
            rw_r      <= 1'b0;
            overrun_r <= 1'b0;
        end else begin
            state_r   <= state_nxt;
            cnt_r     <= cnt_nxt;
            shift_r   <= shift_nxt;
            tx_r      <= tx_nxt;
            ptr_r     <= ptr_nxt;
            phase_r   <= phase_nxt;
            oe_r      <= oe_nxt;
            busy_r    <= busy_nxt;
            wr_r      <= wr_nxt;
            waddr_r   <= waddr_nxt;
            wdata_r   <= wdata_nxt;
            match_r   <= match_nxt;
            ack_rx_r  <= ack_rx_nxt;
            rw_r      <= rw_nxt;
            overrun_r <= overrun_nxt;
        end
    end

    // Register file storage.
    always_ff @(posedge iClock or negedge iReset) begin
        if (!iReset) begin
            for (int i = 0; i < 256; i++) regs_r[i] <= 8'h00;
        end else if (mem_we_s) begin
            regs_r[ptr_r] <= rx_byte_s;
        end else begin
            regs_r[ptr_r] <= regs_r[ptr_r];
        end
    end

    assign oSDA_OE   = oe_r;
    assign oRegWrite = wr_r;
    assign oRegAddr  = waddr_r;
    assign oRegData  = wdata_r;
    assign oBusy     = busy_r;
    assign oLED      = {state_r, match_r, ack_rx_r, rw_r, overrun_r};

endmodule

// File: tb/tb_sccb_slave.sv
// Bench for sccb_slave: bit-banged I2C master against a byte-level model of
// the register file, pointer and overrun flag.
module tb_sccb_slave;
    localparam int Q = 12;

    logic       clk = 1'b0;
    logic       rst_n, scl_m, sda_m;
    wire        sda_line;
    logic       oe, wr, busy;
    logic [7:0] waddr, wdata, led;

    int         checks = 0;
    int         errors = 0;
    int         oe_cnt = 0;
    logic [15:0] got_q [$];
    logic [15:0] exp_q [$];
    int         wr_idx = 0;
    logic [7:0] mem_m [256];
    logic [7:0] ptr_m;
    logic       ovr_m;
    logic [7:0] wq [$];

    assign sda_line = sda_m & ~oe;
    always #5 clk = ~clk;

    sccb_slave dut (
        .iClock(clk), .iReset(rst_n), .iSCL(scl_m), .iSDA(sda_line),
        .oSDA_OE(oe), .oRegWrite(wr), .oRegAddr(waddr), .oRegData(wdata),
        .oBusy(busy), .oLED(led)
    );

    // Collect committed writes and count cycles with SDA pulled low.
    always @(negedge clk) begin
        if (rst_n && wr) got_q.push_back({waddr, wdata});
        if (oe) oe_cnt <= oe_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_q(input int n);
        repeat (n * Q) @(negedge clk);
    endtask

    task automatic i2c_start();
        if (scl_m == 1'b0) begin
            wait_q(1); sda_m = 1'b1; wait_q(1); scl_m = 1'b1; wait_q(1);
        end
        sda_m = 1'b0; wait_q(1); scl_m = 1'b0;
    endtask

    task automatic i2c_stop();
        wait_q(1); sda_m = 1'b0; wait_q(1); scl_m = 1'b1; wait_q(1); sda_m = 1'b1; wait_q(2);
    endtask

    task automatic clock_bit(input logic b, output logic s);
        wait_q(1); sda_m = b; wait_q(1); scl_m = 1'b1; wait_q(1); s = sda_line; wait_q(1); scl_m = 1'b0;
    endtask

    task automatic wr_byte(input logic [7:0] d, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) clock_bit(d[i], s);
        clock_bit(1'b1, s);
        ack = ~s;
    endtask

    task automatic rd_byte(input logic ack, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            clock_bit(1'b1, s);
            d[i] = s;
        end
        clock_bit(~ack, s);
    endtask

    task automatic check_writes();
        check("nwr", got_q.size(), exp_q.size());
        for (int i = wr_idx; i < exp_q.size() && i < got_q.size(); i++)
            check("wr", {16'h0, got_q[i]}, {16'h0, exp_q[i]});
        wr_idx = exp_q.size();
    endtask

    task automatic model_reset();
        for (int i = 0; i < 256; i++) mem_m[i] = 8'h00;
        ptr_m = 8'h00;
        ovr_m = 1'b0;
    endtask

    // Write burst of the bytes in wq to sub-address sub.
    task automatic do_write(input logic [7:0] sub);
        logic a;
        i2c_start();
        wr_byte(8'h42, a); check("addr_ack", a, 1);
        check("busy_on", busy, 1);
        wr_byte(sub, a); check("sub_ack", a, 1);
        ptr_m = sub;
        foreach (wq[k]) begin
            wr_byte(wq[k], a); check("data_ack", a, 1);
            if (ptr_m != 8'h0A && ptr_m != 8'h0B) mem_m[ptr_m] = wq[k];
            exp_q.push_back({ptr_m, wq[k]});
            if (ptr_m == 8'hFF) ovr_m = 1'b1;
            ptr_m = ptr_m + 8'd1;
        end
        i2c_stop();
        check_writes();
        check("busy_off", busy, 0);
        check("idle", led[7:4], 0);
        check("rw_w", led[1], 0);
        check("overrun", led[0], ovr_m);
    endtask

    // Read n bytes, optionally setting the pointer first; last byte is NACKed.
    task automatic do_read(input logic set_ptr, input logic [7:0] sub, input int n);
        logic a;
        logic [7:0] d, e;
        i2c_start();
        if (set_ptr) begin
            wr_byte(8'h42, a); check("addr_ack", a, 1);
            wr_byte(sub, a); check("sub_ack", a, 1);
            ptr_m = sub;
            i2c_start();
        end
        wr_byte(8'h43, a); check("raddr_ack", a, 1);
        for (int k = 0; k < n; k++) begin
            rd_byte(k < n - 1, d);
            e = (ptr_m == 8'h0A) ? 8'h76 : (ptr_m == 8'h0B) ? 8'h73 : mem_m[ptr_m];
            ptr_m = ptr_m + 8'd1;
            check("rd", d, e);
        end
        check("nack_busy", busy, 0);
        check("nack_oe", oe, 0);
        check("ignore", (led[7:4] != 4'd0), 1);
        check("rw_r", led[1], 1);
        i2c_stop();
        check("idle", led[7:4], 0);
        check_writes();
    endtask

    initial begin
        logic a, s;
        int   op, n;
        logic [7:0] sub;
        logic [7:0] picks [6];
        picks[0] = 8'h0A; picks[1] = 8'h0B; picks[2] = 8'hFE;
        picks[3] = 8'hFF; picks[4] = 8'h00; picks[5] = 8'h3A;

        scl_m = 1'b1; sda_m = 1'b1; rst_n = 1'b0;
        model_reset();
        repeat (5) @(negedge clk);
        check("rst_oe", oe, 0); check("rst_wr", wr, 0); check("rst_busy", busy, 0);
        check("rst_addr", waddr, 0); check("rst_data", wdata, 0); check("rst_led", led, 0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        wq = '{8'h80}; do_write(8'h12);
        check("regaddr", waddr, 8'h12); check("regdata", wdata, 8'h80);
        wq = '{8'h04}; do_write(8'h3A);
        do_read(1'b1, 8'h3A, 1);
        do_read(1'b1, 8'h0A, 2);
        wq = '{8'h55}; do_write(8'h0A);
        do_read(1'b1, 8'h0A, 1);

        // Foreign address: never ACKed, never busy, nothing written.
        n = oe_cnt;
        i2c_start();
        wr_byte(8'h60, a); check("mis_ack", a, 0); check("mis_busy", busy, 0);
        wr_byte(8'h12, a); check("mis_ack2", a, 0);
        i2c_stop();
        check("mis_oe", oe_cnt, n);
        check_writes();

        wq = '{8'h11, 8'h22, 8'h33}; do_write(8'hFE);
        do_read(1'b1, 8'hFE, 3);

        // STOP after four data bits discards the partial byte.
        i2c_start();
        wr_byte(8'h42, a); wr_byte(8'h20, a); ptr_m = 8'h20;
        for (int i = 0; i < 4; i++) clock_bit(1'b0, s);
        i2c_stop();
        check_writes();
        check("abort_idle", led[7:4], 0);
        check("abort_busy", busy, 0);

        // One-cycle SDA glitch while SCL high must not look like START.
        sda_m = 1'b0; @(negedge clk); sda_m = 1'b1;
        repeat (30) @(negedge clk);
        check("glitch_idle", led[7:4], 0);
        check("glitch_busy", busy, 0);

        // Reset while driving a 0 data bit in RDATA.
        i2c_start();
        wr_byte(8'h42, a); wr_byte(8'h3A, a); ptr_m = 8'h3A;
        i2c_start();
        wr_byte(8'h43, a);
        wait_q(1);
        check("rd_drive", oe, 1);
        rst_n = 1'b0;
        #1;
        check("arst_oe", oe, 0);
        check("arst_busy", busy, 0);
        check("arst_led", led, 0);
        scl_m = 1'b1; sda_m = 1'b1;
        repeat (10) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        repeat (10) @(negedge clk);
        do_read(1'b1, 8'h3A, 1);
        do_read(1'b1, 8'h12, 1);
        do_read(1'b1, 8'h0A, 2);

        for (int it = 0; it < 16; it++) begin
            op = $urandom_range(0, 2);
            sub = ($urandom_range(0, 2) == 0) ? picks[$urandom_range(0, 5)] : 8'($urandom);
            n = $urandom_range(1, 4);
            if (op == 0) begin
                wq.delete();
                for (int k = 0; k < n; k++) wq.push_back(8'($urandom));
                do_write(sub);
            end else begin
                do_read(op == 1, sub, n);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
